ppm_demod_seq: RTL and testbench
================================

// Module: ppm_demod_seq
// PURPOSE
//  Parametrised successor to the 16-PPM demodulator: M-ary PPM (M = 2**SYM_BITS slots) with
//  oversampled chips. Each chip's SPAD hits are integrated into a saturating magnitude.
//  The symbol decision is a sequential running arg-max, not a parallel correlator.
//  Adds a valid/ready output handshake, erasure flagging, overflow detection and a rx_abort input.
//  Sits between the SPAD front-end sampler and the RX symbol FIFO.
// PARAMETERS
//  SYM_BITS      4       bits per symbol; M = 2**SYM_BITS slots per symbol
//  OSR           4       din samples (clk cycles) per chip, >=1
//  CHIP_BITS     3       chip magnitude width; saturates at 2**CHIP_BITS-1
//  PRE_SYM       0       preamble symbol value
//  PRE_MIN       2       preamble symbols (incl. acquisition) required before SFD
//  SFD0, SFD1    9, 6    start-frame-delimiter symbols, in order
//  LEN_BITS      16      data length field width; sent MSB-first in LEN_BITS/SYM_BITS symbols
// PORTS
//  clk              in   1          clock
//  resetn           in   1          async active-low reset
//  din              in   1          SPAD hit sample, one per clk
//  rx_start         in   1          pulse: IDLE->SCAN; clears overflow
//  rx_abort         in   1          pulse: any state->IDLE next cycle; drops pending dout
//  corr_threshold   in   CHIP_BITS  min peak magnitude for a non-erased symbol
//  dout             out  SYM_BITS   decided data symbol
//  dout_erasure     out  1          peak < corr_threshold for this symbol
//  dout_valid       out  1          dout/dout_erasure held until dout_ready
//  dout_ready       in   1          FIFO accept
//  packet_detected  out  1          1-cycle pulse on entry to DATA
//  packet_done      out  1          1-cycle pulse when the last data symbol is decided
//  overflow         out  1          sticky: data symbol lost because dout_valid && !dout_ready
//  state_o          out  3          FSM state, for scan chain
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; counters, running max and length are 0.
//  Chip timing: sample counter 0..OSR-1. mag += din, saturating. Chip ends at sample OSR-1.
//   Slot counter 0..M-1 advances per chip and wraps.
//  Running max: at chip end, if mag > max (strict) then max<=mag, argmax<=slot. Ties keep the lower slot.
//   At slot M-1 end the symbol is decided; max/argmax are reinitialised for the next symbol.
//   Erasure = (max < corr_threshold).
//  FSM states: IDLE(0) SCAN(1) PREAMBLE(2) SFD0(3) SFD1(4) HDR_LEN(5) DATA(6).
//   IDLE:     counters held; rx_start -> SCAN.
//   SCAN:     chip timing free-runs. First chip with mag>=corr_threshold is taken as slot PRE_SYM:
//             slot<=PRE_SYM+1, max<=mag, argmax<=PRE_SYM, pre_cnt<=1 -> PREAMBLE.
//   PREAMBLE: symbol == PRE_SYM && !erasure: pre_cnt++ (saturating).
//             symbol == SFD0 && pre_cnt>=PRE_MIN -> SFD1 wait state (SFD0 matched).
//             Any other symbol -> SCAN.
//   SFD0/SFD1: SFD0 matched; next symbol == SFD1 -> HDR_LEN, else -> SCAN. Erased -> SCAN.
//   HDR_LEN:  shift symbols into len, MSB-first, for LEN_BITS/SYM_BITS symbols.
//             len==0 -> IDLE with packet_done pulse; else -> DATA with packet_detected pulse.
//   DATA:     each decision loads dout/dout_erasure and sets dout_valid (erased symbols still emitted).
//             After len symbols -> IDLE with packet_done.
//  Handshake: dout_valid clears in the cycle after dout_valid&&dout_ready.
//   Decision while valid&&!ready: new symbol dropped, overflow<=1, count still advances.
//   Decision in the same cycle as accept: new symbol loaded, valid stays 1.
//  Latency: dout_valid rises 1 clk after the last sample of slot M-1.
//  rx_abort beats every other event. rx_start outside IDLE is ignored.
//   Async reset mid-packet returns to IDLE with no outputs asserted.
//  Widths: data counter is LEN_BITS wide, compared to len; len = 2**LEN_BITS-1 must not wrap.
// STRUCTURE
//  ppm_pkg: state enum/localparams, default PRE_SYM/SFD0/SFD1, state width.
//  Sub-module ppm_chip_integrator: sample counter + saturating mag, emits chip_end/mag.
//  Top holds slot counter, running arg-max, FSM, length/data counters, output register.
// TESTING (defaults, corr_threshold=2, dout_ready=1 unless noted)
//  Clean packet: 3 preamble, SFD 9,6, len 0x0002, data 5,A; each pulse=4 hits.
//   -> packet_detected once; dout 5 then A; packet_done on 2nd data symbol.
//  Tie: slots 3 and 7 both mag 4 -> dout=3, dout_erasure=0.
//   Peak mag 1 -> dout_erasure=1, symbol still emitted.
//  Saturation: CHIP_BITS=2, 4 hits in one chip -> mag 3, no wrap.
//  Bad SFD: preamble then symbol 2 -> state SCAN, no packet_detected.
//  Backpressure: dout_ready=0 over 2 data symbols -> first held; second dropped; overflow=1
//   until next rx_start.
//  Abort/reset: rx_abort mid-DATA -> IDLE next clk, dout_valid=0.
//   resetn low mid-HDR_LEN -> all outputs 0.
//   len=0 header -> packet_done, no dout_valid.

Source files
------------

// File: rtl/ppm_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ppm_pkg: state encoding and default framing symbols for ppm_demod_seq. Rev 1.0
// ---------------------------------------------------------------------------
package ppm_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE     = 3'd0,
        ST_SCAN     = 3'd1,
        ST_PREAMBLE = 3'd2,
        ST_SFD0     = 3'd3,
        ST_SFD1     = 3'd4,
        ST_HDR_LEN  = 3'd5,
        ST_DATA     = 3'd6
    } state_e;

    localparam int DEF_PRE_SYM = 0;
    localparam int DEF_SFD0    = 9;
    localparam int DEF_SFD1    = 6;

endpackage
`default_nettype wire

// File: rtl/ppm_chip_integrator.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ppm_chip_integrator: per-chip sample counter and saturating hit magnitude. Rev 1.0
// ---------------------------------------------------------------------------
module ppm_chip_integrator #(
    parameter int OSR       = 4,
    parameter int CHIP_BITS = 3
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 run,
    input  logic                 din,
    output logic                 chip_end,
    output logic [CHIP_BITS-1:0] mag
);

    localparam int                  SAMP_W    = (OSR > 1) ? $clog2(OSR) : 1;
    localparam logic [SAMP_W-1:0]   SAMP_LAST = SAMP_W'(OSR - 1);
    localparam logic [CHIP_BITS-1:0] MAG_MAX  = '1;

    logic [SAMP_W-1:0]    samp_q, samp_d;
    logic [CHIP_BITS-1:0] acc_q, acc_d;

    // mag already includes the current sample so the chip-end value is complete
    always_comb begin
        mag      = (din && (acc_q != MAG_MAX)) ? acc_q + CHIP_BITS'(1) : acc_q;
        chip_end = run && (samp_q == SAMP_LAST);
        samp_d   = samp_q;
        acc_d    = acc_q;
        if (!run || chip_end) begin
            samp_d = '0;
            acc_d  = '0;
        end else begin
            samp_d = samp_q + SAMP_W'(1);
            acc_d  = mag;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            samp_q <= '0;
            acc_q  <= '0;
        end else begin
            samp_q <= samp_d;
            acc_q  <= acc_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ppm_demod_seq.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ppm_demod_seq: M-ary PPM packet demodulator with sequential arg-max decision. Rev 1.0
// ---------------------------------------------------------------------------
module ppm_demod_seq
    import ppm_pkg::*;
#(
    parameter int SYM_BITS  = 4,
    parameter int OSR       = 4,
    parameter int CHIP_BITS = 3,
    parameter int PRE_SYM   = DEF_PRE_SYM,
    parameter int PRE_MIN   = 2,
    parameter int SFD0      = DEF_SFD0,
    parameter int SFD1      = DEF_SFD1,
    parameter int LEN_BITS  = 16
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 din,
    input  logic                 rx_start,
    input  logic                 rx_abort,
    input  logic [CHIP_BITS-1:0] corr_threshold,
    output logic [SYM_BITS-1:0]  dout,
    output logic                 dout_erasure,
    output logic                 dout_valid,
    input  logic                 dout_ready,
    output logic                 packet_detected,
    output logic                 packet_done,
    output logic                 overflow,
    output logic [STATE_W-1:0]   state_o
);

    localparam int HDR_SYMS = LEN_BITS / SYM_BITS;
    localparam int HDR_W    = $clog2(HDR_SYMS) + 1;
    localparam int PRE_W    = $clog2(PRE_MIN + 1) + 1;

    localparam logic [SYM_BITS-1:0] SLOT_LAST = '1;
    localparam logic [SYM_BITS-1:0] PRE_S     = SYM_BITS'(PRE_SYM);
    localparam logic [SYM_BITS-1:0] SFD0_S    = SYM_BITS'(SFD0);
    localparam logic [SYM_BITS-1:0] SFD1_S    = SYM_BITS'(SFD1);
    localparam logic [PRE_W-1:0]    PRE_MIN_C = PRE_W'(PRE_MIN);
    localparam logic [HDR_W-1:0]    HDR_LAST  = HDR_W'(HDR_SYMS - 1);

    state_e               state_q, state_d;
    logic [SYM_BITS-1:0]  slot_q, slot_d;
    logic [CHIP_BITS-1:0] max_q, max_d;
    logic [SYM_BITS-1:0]  argmax_q, argmax_d;
    logic [PRE_W-1:0]     pre_cnt_q, pre_cnt_d;
    logic [HDR_W-1:0]     hdr_cnt_q, hdr_cnt_d;
    logic [LEN_BITS-1:0]  len_q, len_d;
    logic [LEN_BITS-1:0]  data_cnt_q, data_cnt_d;
    logic [SYM_BITS-1:0]  dout_q, dout_d;
    logic                 dout_erasure_q, dout_erasure_d;
    logic                 dout_valid_q, dout_valid_d;
    logic                 packet_detected_q, packet_detected_d;
    logic                 packet_done_q, packet_done_d;
    logic                 overflow_q, overflow_d;

    logic                 w_run;
    logic                 w_chip_end;
    logic [CHIP_BITS-1:0] w_mag;
    logic                 w_higher;
    logic                 w_sym_done;
    logic [SYM_BITS-1:0]  w_sym;
    logic [CHIP_BITS-1:0] w_peak;
    logic                 w_erased;
    logic [LEN_BITS-1:0]  w_new_len;

    // abort clears the integrator in the same cycle the FSM is sent to IDLE
    assign w_run = (state_q != ST_IDLE) && !rx_abort;

    ppm_chip_integrator #(
        .OSR       (OSR),
        .CHIP_BITS (CHIP_BITS)
    ) u_chip (
        .clk      (clk),
        .resetn   (resetn),
        .run      (w_run),
        .din      (din),
        .chip_end (w_chip_end),
        .mag      (w_mag)
    );

    always_comb begin
        w_higher   = w_mag > max_q;
        w_sym_done = w_chip_end && (slot_q == SLOT_LAST) && (state_q != ST_SCAN);
        w_sym      = w_higher ? slot_q : argmax_q;
        w_peak     = w_higher ? w_mag : max_q;
        w_erased   = w_peak < corr_threshold;
        w_new_len  = (len_q << SYM_BITS) | LEN_BITS'(w_sym);
    end

    always_comb begin
        state_d           = state_q;
        slot_d            = slot_q;
        max_d             = max_q;
        argmax_d          = argmax_q;
        pre_cnt_d         = pre_cnt_q;
        hdr_cnt_d         = hdr_cnt_q;
        len_d             = len_q;
        data_cnt_d        = data_cnt_q;
        dout_d            = dout_q;
        dout_erasure_d    = dout_erasure_q;
        dout_valid_d      = dout_valid_q;
        packet_detected_d = 1'b0;
        packet_done_d     = 1'b0;
        overflow_d        = overflow_q;

        if (dout_valid_q && dout_ready) begin
            dout_valid_d = 1'b0;
        end

        // Strict compare in ascending slot order resolves ties to the lower slot
        if (w_chip_end && (state_q != ST_SCAN)) begin
            if (slot_q == SLOT_LAST) begin
                slot_d   = '0;
                max_d    = '0;
                argmax_d = '0;
            end else begin
                slot_d = slot_q + SYM_BITS'(1);
                if (w_higher) begin
                    max_d    = w_mag;
                    argmax_d = slot_q;
                end
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (rx_start) begin
                    state_d    = ST_SCAN;
                    overflow_d = 1'b0;
                end
            end
            ST_SCAN: begin
                if (w_chip_end && (w_mag >= corr_threshold)) begin
                    state_d   = ST_PREAMBLE;
                    slot_d    = PRE_S + SYM_BITS'(1);
                    max_d     = w_mag;
                    argmax_d  = PRE_S;
                    pre_cnt_d = PRE_W'(1);
                end
            end
            ST_PREAMBLE: begin
                if (w_sym_done) begin
                    if (!w_erased && (w_sym == PRE_S)) begin
                        if (pre_cnt_q < PRE_MIN_C) begin
                            pre_cnt_d = pre_cnt_q + PRE_W'(1);
                        end
                    end else if (!w_erased && (w_sym == SFD0_S) && (pre_cnt_q >= PRE_MIN_C)) begin
                        state_d = ST_SFD1;
                    end else begin
                        state_d = ST_SCAN;
                    end
                end
            end
            ST_SFD0, ST_SFD1: begin
                if (w_sym_done) begin
                    hdr_cnt_d = '0;
                    state_d   = (!w_erased && (w_sym == SFD1_S)) ? ST_HDR_LEN : ST_SCAN;
                end
            end
            ST_HDR_LEN: begin
                if (w_sym_done) begin
                    len_d     = w_new_len;
                    hdr_cnt_d = hdr_cnt_q + HDR_W'(1);
                    if (hdr_cnt_q == HDR_LAST) begin
                        data_cnt_d = '0;
                        if (w_new_len == '0) begin
                            state_d       = ST_IDLE;
                            packet_done_d = 1'b1;
                        end else begin
                            state_d           = ST_DATA;
                            packet_detected_d = 1'b1;
                        end
                    end
                end
            end
            ST_DATA: begin
                if (w_sym_done) begin
                    if (!dout_valid_q || dout_ready) begin
                        dout_d         = w_sym;
                        dout_erasure_d = w_erased;
                        dout_valid_d   = 1'b1;
                    end else begin
                        overflow_d = 1'b1;
                    end
                    data_cnt_d = data_cnt_q + LEN_BITS'(1);
                    if (data_cnt_q == (len_q - LEN_BITS'(1))) begin
                        state_d       = ST_IDLE;
                        packet_done_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (rx_abort) begin
            state_d           = ST_IDLE;
            slot_d            = '0;
            max_d             = '0;
            argmax_d          = '0;
            pre_cnt_d         = '0;
            hdr_cnt_d         = '0;
            len_d             = '0;
            data_cnt_d        = '0;
            dout_valid_d      = 1'b0;
            packet_detected_d = 1'b0;
            packet_done_d     = 1'b0;
            overflow_d        = overflow_q;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q           <= ST_IDLE;
            slot_q            <= '0;
            max_q             <= '0;
            argmax_q          <= '0;
            pre_cnt_q         <= '0;
            hdr_cnt_q         <= '0;
            len_q             <= '0;
            data_cnt_q        <= '0;
            dout_q            <= '0;
            dout_erasure_q    <= 1'b0;
            dout_valid_q      <= 1'b0;
            packet_detected_q <= 1'b0;
            packet_done_q     <= 1'b0;
            overflow_q        <= 1'b0;
        end else begin
            state_q           <= state_d;
            slot_q            <= slot_d;
            max_q             <= max_d;
            argmax_q          <= argmax_d;
            pre_cnt_q         <= pre_cnt_d;
            hdr_cnt_q         <= hdr_cnt_d;
            len_q             <= len_d;
            data_cnt_q        <= data_cnt_d;
            dout_q            <= dout_d;
            dout_erasure_q    <= dout_erasure_d;
            dout_valid_q      <= dout_valid_d;
            packet_detected_q <= packet_detected_d;
            packet_done_q     <= packet_done_d;
            overflow_q        <= overflow_d;
        end
    end

    assign dout            = dout_q;
    assign dout_erasure    = dout_erasure_q;
    assign dout_valid      = dout_valid_q;
    assign packet_detected = packet_detected_q;
    assign packet_done     = packet_done_q;
    assign overflow        = overflow_q;
    assign state_o         = state_q;

endmodule
`default_nettype wire

// File: tb/tb_ppm_demod_seq.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_ppm_demod_seq: directed self-checking bench for ppm_demod_seq. Rev 1.0
// ---------------------------------------------------------------------------
module tb_ppm_demod_seq;

    logic       clk;
    logic       resetn;
    logic       din;
    logic       rx_start;
    logic       rx_abort;
    logic       dout_ready;
    logic [2:0] thr;
    logic [1:0] thr2;

    logic [3:0] dout;
    logic       dout_erasure, dout_valid, packet_detected, packet_done, overflow;
    logic [2:0] state_o;

    logic [3:0] dout2;
    logic       dout_erasure2, dout_valid2, packet_detected2, packet_done2, overflow2;
    logic [2:0] state2;

    int checks   = 0;
    int failures = 0;
    int det_cnt  = 0;

    ppm_demod_seq dut (
        .clk             (clk),
        .resetn          (resetn),
        .din             (din),
        .rx_start        (rx_start),
        .rx_abort        (rx_abort),
        .corr_threshold  (thr),
        .dout            (dout),
        .dout_erasure    (dout_erasure),
        .dout_valid      (dout_valid),
        .dout_ready      (dout_ready),
        .packet_detected (packet_detected),
        .packet_done     (packet_done),
        .overflow        (overflow),
        .state_o         (state_o)
    );

    // Narrow-magnitude copy sharing all stimulus, used for the saturation case
    ppm_demod_seq #(.CHIP_BITS(2)) dut2 (
        .clk             (clk),
        .resetn          (resetn),
        .din             (din),
        .rx_start        (rx_start),
        .rx_abort        (rx_abort),
        .corr_threshold  (thr2),
        .dout            (dout2),
        .dout_erasure    (dout_erasure2),
        .dout_valid      (dout_valid2),
        .dout_ready      (dout_ready),
        .packet_detected (packet_detected2),
        .packet_done     (packet_done2),
        .overflow        (overflow2),
        .state_o         (state2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (packet_detected === 1'b1) det_cnt++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chip(input int h);
        for (int i = 0; i < 4; i++) begin
            din = (i < h);
            tick();
        end
        din = 1'b0;
    endtask

    task automatic sym2(input int sa, input int ha, input int sb, input int hb);
        for (int s = 0; s < 16; s++) begin
            chip((s == sa) ? ha : ((s == sb) ? hb : 0));
        end
    endtask

    task automatic sym(input int s);
        sym2(s, 4, s, 4);
    endtask

    task automatic header(input int len);
        for (int k = 3; k >= 0; k--) begin
            sym((len >> (4 * k)) & 15);
        end
    endtask

    task automatic pulse_start();
        rx_start = 1'b1;
        tick();
        rx_start = 1'b0;
    endtask

    task automatic pulse_abort();
        rx_abort = 1'b1;
        tick();
        rx_abort = 1'b0;
    endtask

    initial begin
        resetn     = 1'b0;
        din        = 1'b0;
        rx_start   = 1'b0;
        rx_abort   = 1'b0;
        dout_ready = 1'b1;
        thr        = 3'd2;
        thr2       = 2'd2;
        repeat (3) tick();
        chk("rst_valid", 32'(dout_valid), 32'd0);
        chk("rst_state", 32'(state_o), 32'd0);
        chk("rst_det", 32'(packet_detected), 32'd0);
        chk("rst_done", 32'(packet_done), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_dout", 32'(dout), 32'd0);
        resetn = 1'b1;
        tick();

        // Clean packet: 3 preambles, SFD, len 2, data 5 then A
        pulse_start();
        chk("p1_scan", 32'(state_o), 32'd1);
        sym(0);
        chk("p1_pre", 32'(state_o), 32'd2);
        sym(0);
        sym(0);
        sym(9);
        chk("p1_sfd0", 32'(state_o), 32'd4);
        sym(6);
        chk("p1_hdr", 32'(state_o), 32'd5);
        header(2);
        chk("p1_det", 32'(packet_detected), 32'd1);
        chk("p1_data", 32'(state_o), 32'd6);
        sym(5);
        chk("p1_v0", 32'(dout_valid), 32'd1);
        chk("p1_d0", 32'(dout), 32'd5);
        chk("p1_e0", 32'(dout_erasure), 32'd0);
        sym(10);
        chk("p1_d1", 32'(dout), 32'd10);
        chk("p1_done", 32'(packet_done), 32'd1);
        chk("p1_idle", 32'(state_o), 32'd0);
        tick();
        chk("p1_vclr", 32'(dout_valid), 32'd0);
        chk("p1_detcnt", 32'(det_cnt), 32'd1);

        // Tie, weak peak, and saturation on the 2-bit copy
        pulse_start();
        sym(0);
        sym(0);
        sym(9);
        sym(6);
        header(3);
        sym2(3, 4, 7, 4);
        chk("tie_dout", 32'(dout), 32'd3);
        chk("tie_eras", 32'(dout_erasure), 32'd0);
        sym2(5, 1, 5, 1);
        chk("weak_valid", 32'(dout_valid), 32'd1);
        chk("weak_eras", 32'(dout_erasure), 32'd1);
        chk("weak_dout", 32'(dout), 32'd5);
        chk("weak_eras2", 32'(dout_erasure2), 32'd1);
        sym2(2, 4, 6, 3);
        chk("sat_dout", 32'(dout), 32'd2);
        chk("sat_done", 32'(packet_done), 32'd1);
        chk("sat_dout2", 32'(dout2), 32'd2);
        chk("sat_valid2", 32'(dout_valid2), 32'd1);
        chk("sat_eras2", 32'(dout_erasure2), 32'd0);
        chk("sat_done2", 32'(packet_done2), 32'd1);
        chk("sat_state2", 32'(state2), 32'd0);
        chk("sat_ovf2", 32'(overflow2), 32'd0);
        chk("sat_det2", 32'(packet_detected2), 32'd0);

        // Bad SFD falls back to SCAN
        pulse_start();
        sym(0);
        sym(0);
        sym(2);
        chk("bad_sfd_state", 32'(state_o), 32'd1);
        chk("bad_sfd_det", 32'(det_cnt), 32'd2);
        pulse_abort();
        chk("bad_sfd_abort", 32'(state_o), 32'd0);

        // Backpressure: first symbol held, second dropped
        pulse_start();
        sym(0);
        sym(0);
        sym(9);
        sym(6);
        header(2);
        dout_ready = 1'b0;
        sym(1);
        chk("bp_v0", 32'(dout_valid), 32'd1);
        chk("bp_d0", 32'(dout), 32'd1);
        chk("bp_ovf0", 32'(overflow), 32'd0);
        sym(2);
        chk("bp_hold", 32'(dout), 32'd1);
        chk("bp_ovf1", 32'(overflow), 32'd1);
        chk("bp_done", 32'(packet_done), 32'd1);
        dout_ready = 1'b1;
        tick();
        chk("bp_vclr", 32'(dout_valid), 32'd0);
        chk("bp_sticky", 32'(overflow), 32'd1);
        tick();
        pulse_start();
        chk("bp_ovfclr", 32'(overflow), 32'd0);
        chk("bp_scan", 32'(state_o), 32'd1);

        // Abort mid-DATA with a pending output
        sym(0);
        sym(0);
        sym(9);
        sym(6);
        header(4);
        dout_ready = 1'b0;
        sym(7);
        chk("ab_valid", 32'(dout_valid), 32'd1);
        chk("ab_dout", 32'(dout), 32'd7);
        pulse_abort();
        chk("ab_state", 32'(state_o), 32'd0);
        chk("ab_vclr", 32'(dout_valid), 32'd0);
        dout_ready = 1'b1;

        // Asynchronous reset mid-header
        pulse_start();
        sym(0);
        sym(0);
        sym(9);
        sym(6);
        sym(0);
        sym(0);
        chk("rs_hdr", 32'(state_o), 32'd5);
        #2;
        resetn = 1'b0;
        #2;
        chk("rs_dout", 32'(dout), 32'd0);
        chk("rs_state", 32'(state_o), 32'd0);
        chk("rs_valid", 32'(dout_valid), 32'd0);
        chk("rs_ovf", 32'(overflow), 32'd0);
        chk("rs_done", 32'(packet_done), 32'd0);
        resetn = 1'b1;
        tick();

        // Zero-length header
        pulse_start();
        sym(0);
        sym(0);
        sym(9);
        sym(6);
        header(0);
        chk("len0_done", 32'(packet_done), 32'd1);
        chk("len0_state", 32'(state_o), 32'd0);
        chk("len0_valid", 32'(dout_valid), 32'd0);
        chk("len0_detcnt", 32'(det_cnt), 32'd4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
